axi_stream_header_extract: RTL and testbench
============================================

AXI_STREAM_HEADER_EXTRACT -- requirements
Module: axi_stream_header_extract

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD)+1, width of the header byte count.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port hdr_byte_cnt, input, BYTE_CNT_WD, header length S in bytes, legal 1..DATA_BYTE_WD.
REQ-007 SHALL have input-stream ports: valid_in (in, 1), data_in (in, DATA_WD), keep_in (in, DATA_BYTE_WD), last_in (in, 1), ready_in (out, 1).
REQ-008 SHALL have header-output ports: valid_hdr (out, 1), data_hdr (out, DATA_WD), keep_hdr (out, DATA_BYTE_WD), ready_hdr (in, 1).
REQ-009 SHALL have payload-output ports: valid_out (out, 1), data_out (out, DATA_WD), keep_out (out, DATA_BYTE_WD), last_out (out, 1), ready_out (in, 1).
REQ-010 SHALL have port runt_err, output, 1, one-cycle pulse when a packet carries no payload bytes.

Function
REQ-011 SHALL use this byte order on the input and payload streams: byte 0 = data[DATA_WD-1 -: 8]; keep is left-justified; all beats except the last carry full keep.
REQ-012 SHALL present the header in data_hdr right-justified, with unused bytes zero and keep_hdr equal to the low S bits set.
REQ-013 SHALL sample S when the first beat of a packet is accepted; values 0 or >DATA_BYTE_WD clamp to DATA_BYTE_WD.
REQ-014 SHALL implement FSM states HDR (awaiting first beat), PAYLOAD, and FLUSH, and SHALL enter HDR after reset.
REQ-015 In HDR, ready_in SHALL be (!valid_hdr | ready_hdr) & (!valid_out | ready_out).
REQ-016 In PAYLOAD, ready_in SHALL be (!valid_out | ready_out); in FLUSH, ready_in SHALL be 0.
REQ-017 On first-beat accept: the top S bytes SHALL load the header register (valid_hdr=1 next cycle), and the remaining R=DATA_BYTE_WD-S bytes SHALL load the residual register.
REQ-018 On a PAYLOAD accept of k valid bytes: the output beat SHALL be {residual R bytes, top S bytes of input}, registered, with valid_out the next cycle (latency 1); the low R input bytes SHALL become the new residual.
REQ-019 On the last beat, if R+k<=DATA_BYTE_WD: a single output beat SHALL be emitted with keep of R+k MSBs set and last_out=1, and the FSM SHALL go to HDR.
REQ-020 On the last beat, if R+k>DATA_BYTE_WD: a full beat SHALL be emitted, then FLUSH SHALL emit the residual with keep of R+k-DATA_BYTE_WD MSBs and last_out=1 once the output register is free, then go to HDR.
REQ-021 If the first beat has last_in=1 and k<=S, the block SHALL emit no payload, pulse runt_err, and remain in HDR; if k>S, it SHALL emit one payload beat of k-S bytes with last_out=1.
REQ-022 When S=DATA_BYTE_WD (R=0), payload beats SHALL pass through unshifted and FLUSH SHALL never be entered.
REQ-023 The header register SHALL clear on valid_hdr&ready_hdr; the output register SHALL clear on valid_out&ready_out unless reloaded in the same cycle.
REQ-024 Payload flow SHALL NOT wait on header consumption; only the next packet's first beat SHALL stall on an occupied header register.
REQ-025 Output data/keep/last SHALL be held stable while valid_out&!ready_out; likewise the hdr signals while valid_hdr&!ready_hdr.
REQ-026 Unused keep_out bytes SHALL drive zero data.

Reset
REQ-027 While rst=1, the block SHALL drive ready_in=0 and runt_err=0.
REQ-028 One clock with rst=1 SHALL zero valid_out, data_out, keep_out, last_out, valid_hdr, data_hdr, keep_hdr, and the residual register, and set FSM=HDR.
REQ-029 Reset mid-packet SHALL discard the partial packet; the next accepted beat SHALL be treated as a first beat.

Verification
REQ-030 S=2, beats 0xAABBCCDD/F, 0x11223344/F, 0x55660000/C last -> hdr 0x0000AABB/3; out 0xCCDD1122/F, 0x33445566/F last.
REQ-031 S=3, beats 0x01020304/F, 0x05060708/F last -> hdr 0x00010203/7; out 0x04050607/F, 0x08000000/8 last; ready_in=0 during FLUSH.
REQ-032 S=4, single beat 0xDEADBEEF/F last -> hdr 0xDEADBEEF/F, no valid_out, runt_err high exactly 1 cycle.
REQ-033 S=1, random ready_out and ready_hdr stalls over 50 back-to-back packets -> payload equals the input minus the first byte of each packet, no drop/duplication, outputs stable while stalled.
REQ-034 rst asserted after beat 2 of a 4-beat packet -> all outputs zero next cycle; a fresh packet afterwards extracts correctly.
REQ-035 Round-trip: header insert followed by this block with matching S -> the recovered header and payload SHALL match the originals.

Source files
------------

// File: rtl/axi_stream_header_extract.sv
// axi_stream_header_extract: strips an S-byte header from each packet onto a side channel
// and realigns the remaining payload bytes to the start of the output beats.
module axi_stream_header_extract #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BYTE_CNT_WD-1:0]  hdr_byte_cnt,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    runt_err
);
    localparam int CW = BYTE_CNT_WD + 1;
    localparam logic [CW-1:0] NB = CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {HDR, PAYLOAD, FLUSH} state_t;
    state_t state, state_n;

    logic [CW-1:0] s_q, s_n, fcnt_q, fcnt_n, k, r, r_new, tot, s_new;
    logic [DATA_WD-1:0] res_q, res_n, din, o_data;
    logic [DATA_BYTE_WD-1:0] o_keep;
    logic runt_q, runt_n, out_ld, hdr_ld, acc, out_free, o_last;

    function automatic logic [DATA_BYTE_WD-1:0] msb_keep(input logic [CW-1:0] n);
        return ~({DATA_BYTE_WD{1'b1}} >> n);
    endfunction

    // Invalid input bytes are zeroed up front so every shifted result is already clean.
    always_comb begin
        k = '0;
        din = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            k = k + CW'(keep_in[i]);
            din[8*i +: 8] = {8{keep_in[i]}} & data_in[8*i +: 8];
        end
    end

    assign s_new = ({1'b0, hdr_byte_cnt} == '0 || {1'b0, hdr_byte_cnt} > NB) ? NB : {1'b0, hdr_byte_cnt};
    assign r_new = NB - s_new;
    assign r = NB - s_q;
    assign tot = r + k;
    assign runt_err = runt_q && !rst;

    always_comb begin
        state_n = state;
        s_n = s_q;
        fcnt_n = fcnt_q;
        res_n = res_q;
        runt_n = 1'b0;
        out_ld = 1'b0;
        hdr_ld = 1'b0;
        o_data = '0;
        o_keep = '0;
        o_last = 1'b0;
        out_free = !valid_out || ready_out;
        ready_in = rst ? 1'b0 : state == HDR ? (!valid_hdr || ready_hdr) && out_free : state == PAYLOAD && out_free;
        acc = valid_in && ready_in;
        case (state)
            HDR: if (acc) begin
                hdr_ld = 1'b1;
                s_n = s_new;
                res_n = din << {s_new, 3'b0};
                o_data = din << {s_new, 3'b0};
                o_keep = msb_keep(k - s_new);
                o_last = 1'b1;
                out_ld = last_in && k > s_new;
                runt_n = last_in && k <= s_new;
                state_n = last_in ? HDR : PAYLOAD;
            end
            PAYLOAD: if (acc) begin
                out_ld = 1'b1;
                res_n = din << {s_q, 3'b0};
                o_data = res_q | (din >> {r, 3'b0});
                o_last = last_in && tot <= NB;
                o_keep = o_last ? msb_keep(tot) : '1;
                fcnt_n = tot - NB;
                state_n = last_in ? (tot > NB ? FLUSH : HDR) : PAYLOAD;
            end
            FLUSH: if (out_free) begin
                out_ld = 1'b1;
                o_data = res_q;
                o_keep = msb_keep(fcnt_q);
                o_last = 1'b1;
                state_n = HDR;
            end
            default: state_n = HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= HDR;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
            fcnt_q <= '0;
            res_q <= '0;
            runt_q <= 1'b0;
            valid_hdr <= 1'b0;
            data_hdr <= '0;
            keep_hdr <= '0;
            valid_out <= 1'b0;
            data_out <= '0;
            keep_out <= '0;
            last_out <= 1'b0;
        end else begin
            s_q <= s_n;
            fcnt_q <= fcnt_n;
            res_q <= res_n;
            runt_q <= runt_n;
            if (hdr_ld) begin
                valid_hdr <= 1'b1;
                data_hdr <= din >> {r_new, 3'b0};
                keep_hdr <= ~({DATA_BYTE_WD{1'b1}} << s_new);
            end else if (valid_hdr && ready_hdr) begin
                valid_hdr <= 1'b0;
                data_hdr <= '0;
                keep_hdr <= '0;
            end
            if (out_ld) begin
                valid_out <= 1'b1;
                data_out <= o_data;
                keep_out <= o_keep;
                last_out <= o_last;
            end else if (valid_out && ready_out) begin
                valid_out <= 1'b0;
                data_out <= '0;
                keep_out <= '0;
                last_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_stream_header_extract.sv
// tb_axi_stream_header_extract: byte-level scoreboard bench for header extraction and payload realignment.
module tb_axi_stream_header_extract;
    localparam int W = 32;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] hdr_byte_cnt = '0;
    logic valid_in = 1'b0;
    logic last_in = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [N-1:0] keep_in = '0;
    logic ready_in;
    logic valid_hdr;
    logic [W-1:0] data_hdr;
    logic [N-1:0] keep_hdr;
    logic ready_hdr = 1'b1;
    logic valid_out;
    logic [W-1:0] data_out;
    logic [N-1:0] keep_out;
    logic last_out;
    logic ready_out = 1'b1;
    logic runt_err;

    int total = 0;
    int bad = 0;
    int runt_seen = 0;
    int exp_runt = 0;
    bit mon_en = 1'b0;
    bit rand_en = 1'b0;
    logic [7:0] pkt[$];
    logic [W+N-1:0] hq[$];
    logic [W+N:0] oq[$];
    logic [W+N+1:0] prev_o;
    logic [W+N:0] prev_h;
    bit stall_o = 1'b0;
    bit stall_h = 1'b0;

    axi_stream_header_extract dut (
        .clk(clk), .rst(rst), .hdr_byte_cnt(hdr_byte_cnt),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
        .runt_err(runt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Consumer side: pop expectations on every completed handshake, check hold-while-stalled.
    initial forever begin
        @(negedge clk);
        if (mon_en && !rst) begin
            if (valid_hdr && ready_hdr) begin
                chk("hdr_avail", 64'(hq.size() != 0), 1);
                if (hq.size() != 0) chk("hdr", {keep_hdr, data_hdr}, hq.pop_front());
            end
            if (valid_out && ready_out) begin
                chk("out_avail", 64'(oq.size() != 0), 1);
                if (oq.size() != 0) chk("out", {last_out, keep_out, data_out}, oq.pop_front());
            end
            if (runt_err) runt_seen++;
            if (stall_o) chk("out_hold", {valid_out, last_out, keep_out, data_out}, prev_o);
            if (stall_h) chk("hdr_hold", {valid_hdr, keep_hdr, data_hdr}, prev_h);
            stall_o = valid_out && !ready_out;
            stall_h = valid_hdr && !ready_hdr;
            prev_o = {valid_out, last_out, keep_out, data_out};
            prev_h = {valid_hdr, keep_hdr, data_hdr};
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        ready_out = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        ready_hdr = rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic beat(input logic [W-1:0] d, input logic [N-1:0] kp, input logic l);
        int n = 0;
        data_in = d;
        keep_in = kp;
        last_in = l;
        valid_in = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_in && n < 500);
        chk("accept", ready_in, 1);
        @(posedge clk);
        #1;
    endtask

    // Reference: first s bytes form the header, the rest is the payload repacked from byte 0.
    task automatic send_pkt(input logic [2:0] hb, input int s);
        logic [W-1:0] d;
        logic [N-1:0] kp;
        int len = pkt.size();
        d = '0;
        kp = '0;
        for (int i = 0; i < s; i++) begin
            d = {d[W-9:0], pkt[i]};
            kp = {kp[N-2:0], 1'b1};
        end
        hq.push_back({kp, d});
        if (len <= s) exp_runt++;
        for (int j = s; j < len; j += N) begin
            d = '0;
            kp = '0;
            for (int b = 0; b < N; b++) begin
                d = {d[W-9:0], j + b < len ? pkt[j+b] : 8'h00};
                kp = {kp[N-2:0], j + b < len};
            end
            oq.push_back({j + N >= len, kp, d});
        end
        for (int j = 0; j < len; j += N) begin
            d = '0;
            kp = '0;
            for (int b = 0; b < N; b++) begin
                d = {d[W-9:0], j + b < len ? pkt[j+b] : 8'hEE};
                kp = {kp[N-2:0], j + b < len};
            end
            hdr_byte_cnt = j == 0 ? hb : 3'($urandom);
            beat(d, kp, j + N >= len);
        end
        valid_in = 1'b0;
        last_in = 1'b0;
    endtask

    task automatic mk(input int len);
        pkt.delete();
        repeat (len) pkt.push_back(8'($urandom));
    endtask

    task automatic drain();
        int n = 0;
        repeat (3) @(negedge clk);
        while ((hq.size() != 0 || oq.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain", hq.size() + oq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready_in", ready_in, 0);
        chk("rst_runt", runt_err, 0);
        chk("rst_out", {valid_out, last_out, keep_out, data_out}, 0);
        chk("rst_hdr", {valid_hdr, keep_hdr, data_hdr}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_pkt(3'd2, 2);
        drain();
        pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_pkt(3'd3, 3);
        @(negedge clk);
        chk("flush_ready_in", ready_in, 0);
        drain();
        pkt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_pkt(3'd4, 4);
        drain();
        chk("runt_once", runt_seen, 1);
        pkt = '{8'h12, 8'h34, 8'h56};
        send_pkt(3'd1, 1);
        mk(6);
        send_pkt(3'd0, 4);
        mk(9);
        send_pkt(3'd7, 4);
        mk(13);
        send_pkt(3'd4, 4);
        drain();
        rand_en = 1'b1;
        for (int p = 0; p < 50; p++) begin
            mk($urandom_range(2, 13));
            send_pkt(3'd1, 1);
        end
        rand_en = 1'b0;
        drain();
        chk("runt_after_stalls", runt_seen, exp_runt);
        rand_en = 1'b1;
        for (int p = 0; p < 20; p++) begin
            int s = $urandom_range(1, 4);
            mk(s);
            repeat ($urandom_range(1, 10)) pkt.push_back(8'($urandom));
            send_pkt(3'(s), s);
        end
        rand_en = 1'b0;
        drain();
        mon_en = 1'b0;
        hdr_byte_cnt = 3'd1;
        beat(32'h0A0B0C0D, 4'hF, 1'b0);
        beat(32'h1A1B1C1D, 4'hF, 1'b0);
        valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready_in", ready_in, 0);
        chk("midrst_runt", runt_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out", {valid_out, last_out, keep_out, data_out}, 0);
        chk("midrst_hdr", {valid_hdr, keep_hdr, data_hdr}, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        pkt = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        send_pkt(3'd2, 2);
        drain();
        chk("runt_final", runt_seen, exp_runt);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
